// File: rtl/mem32_pkg.sv
// Shared definitions for the Memoria32 preload/sweep blocks: bus widths,
// word stride, the address wrap point and the sequencer state encoding.
package mem32_pkg;

  localparam int MEM_DATA_W     = 32;
  localparam int MEM_ADDR_W     = 32;
  localparam int MEM_WORD_BYTES = 4;
  localparam int MEM_WRAP_ADDR  = 64;
  localparam int MEM_CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } mem32_state_e;

endpackage

// File: rtl/mem32_addr_gen.sv
// Word-address sweep generator: loads a base, then steps by a fixed stride.
// Only an exact hit on the wrap address returns to zero; anything beyond it
// rolls over naturally at 2^ADDR_W.
module mem32_addr_gen
  import mem32_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int ADDR_STEP = MEM_WORD_BYTES,
  parameter int WRAP_ADDR = MEM_WRAP_ADDR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] WRAP_A = ADDR_W'(WRAP_ADDR);
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);

  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] cur_addr_d;

  always_comb begin
    cur_addr_d = cur_addr_q;
    if (load_i) begin
      cur_addr_d = base_i;
    end else if (step_i) begin
      cur_addr_d = (cur_addr_q == WRAP_A) ? '0 : cur_addr_q + STEP_A;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_addr_q <= '0;
    end else begin
      cur_addr_q <= cur_addr_d;
    end
  end

  assign addr_o = cur_addr_q;

endmodule

// File: rtl/mem32_write_sequencer.sv
// Streams handshaked words into Memoria32 as registered single-cycle writes
// at consecutive word addresses starting from a captured, word-aligned base.
//
// state    | meaning
// ST_IDLE  | waiting for start; outputs hold last burst results
// ST_WRITE | in_ready high, one registered write per accepted word
// ST_DONE  | single-cycle done pulse, then back to idle
module mem32_write_sequencer
  import mem32_pkg::*;
#(
  parameter int DATA_W    = MEM_DATA_W,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int ADDR_STEP = MEM_WORD_BYTES,
  parameter int WRAP_ADDR = MEM_WRAP_ADDR,
  parameter int CNT_W     = MEM_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] waddress,
  output logic [DATA_W-1:0] Datain,
  output logic              Wr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  wr_count
);

  mem32_state_e      state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] datain_q, datain_d;
  logic              wr_q, wr_d;

  logic              addr_load;
  logic              addr_step;
  logic [ADDR_W-1:0] base_aligned;
  logic [ADDR_W-1:0] cur_addr;
  logic              handshake;

  assign base_aligned = base_addr & ~(ADDR_W'(3));
  assign handshake    = in_valid && (state_q == ST_WRITE);

  mem32_addr_gen #(
    .ADDR_W    (ADDR_W),
    .ADDR_STEP (ADDR_STEP),
    .WRAP_ADDR (WRAP_ADDR)
  ) u_addr_gen (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .load_i (addr_load),
    .step_i (addr_step),
    .base_i (base_aligned),
    .addr_o (cur_addr)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wr_count_d  = wr_count_q;
    waddr_d     = waddr_q;
    datain_d    = datain_q;
    wr_d        = 1'b0;
    addr_load   = 1'b0;
    addr_step   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_load   = 1'b1;
          remaining_d = word_count;
          wr_count_d  = '0;
          state_d     = (word_count != '0) ? ST_WRITE : ST_DONE;
        end
      end
      ST_WRITE: begin
        if (handshake) begin
          waddr_d     = cur_addr;
          datain_d    = in_data;
          wr_d        = 1'b1;
          wr_count_d  = wr_count_q + CNT_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          addr_step   = 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      wr_count_q  <= '0;
      waddr_q     <= '0;
      datain_q    <= '0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wr_count_q  <= wr_count_d;
      waddr_q     <= waddr_d;
      datain_q    <= datain_d;
      wr_q        <= wr_d;
    end
  end

  // done shares the DONE state with the last word's Wr cycle
  assign in_ready = (state_q == ST_WRITE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign waddress = waddr_q;
  assign Datain   = datain_q;
  assign Wr       = wr_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mem32_write_sequencer.sv
// Self-checking bench for mem32_write_sequencer: a spec-level reference model
// compared every cycle, plus directed bursts with literal write-log checks.
module tb_mem32_write_sequencer;

  logic        CLK;
  logic        RESET;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] waddress;
  logic [31:0] Datain;
  logic        Wr;
  logic        busy;
  logic        done;
  logic [7:0]  wr_count;

  mem32_write_sequencer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .waddress   (waddress),
    .Datain     (Datain),
    .Wr         (Wr),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Phase: 0 idle, 1 accepting words, 2 burst finished.
  int          m_phase;
  int          m_left;
  logic [31:0] m_addr;
  logic [31:0] m_waddr;
  logic [31:0] m_data;
  logic [7:0]  m_cnt;
  logic        m_wr;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_phase <= 0; m_left <= 0; m_addr <= 0; m_waddr <= 0;
      m_data <= 0; m_cnt <= 0; m_wr <= 0;
    end else begin
      m_wr <= 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          m_addr  <= {base_addr[31:2], 2'b00};
          m_left  <= int'(word_count);
          m_cnt   <= 0;
          m_phase <= (word_count == 0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (in_valid) begin
          m_waddr <= m_addr;
          m_data  <= in_data;
          m_wr    <= 1'b1;
          m_cnt   <= m_cnt + 8'd1;
          m_left  <= m_left - 1;
          m_addr  <= (m_addr == 32'd64) ? 32'd0 : m_addr + 32'd4;
          if (m_left == 1) m_phase <= 2;
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  int          cyc_no = 0;
  int          done_n;
  int          done_cyc;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  always @(posedge CLK) cyc_no <= cyc_no + 1;

  always @(negedge CLK) begin
    chk("wr",       {63'd0, Wr},       {63'd0, m_wr});
    chk("done",     {63'd0, done},     {63'd0, (m_phase == 2)});
    chk("busy",     {63'd0, busy},     {63'd0, (m_phase != 0)});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (m_phase == 1)});
    chk("wr_count", {56'd0, wr_count}, {56'd0, m_cnt});
    chk("waddress", {32'd0, waddress}, {32'd0, m_waddr});
    chk("datain",   {32'd0, Datain},   {32'd0, m_data});
    if (Wr) begin
      wa_q.push_back(waddress);
      wd_q.push_back(Datain);
      wc_q.push_back(cyc_no);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc_no;
    end
  end

  task automatic nxt();
    @(negedge CLK);
    #1;
  endtask

  logic [31:0] exp_a[$];
  int          start_cyc;

  task automatic check_writes(input string name, input logic [31:0] d0);
    chk({name, "_nwrites"}, 64'(wa_q.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      chk({name, "_addr"}, {32'd0, wa_q[i]}, {32'd0, exp_a[i]});
      chk({name, "_data"}, {32'd0, wd_q[i]}, {32'd0, d0 + 32'(i)});
    end
  endtask

  task automatic run_burst(input logic [31:0] base, input logic [7:0] cnt, input logic [31:0] d0,
                           input logic [7:0] vpat, input int plen, input int pulse_at,
                           input int rst_after);
    logic finished;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    done_n = 0;
    finished = 1'b0;
    start = 1'b1; base_addr = base; word_count = cnt; in_valid = 1'b0;
    start_cyc = cyc_no;
    nxt();
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_phase == 0) begin
        finished = 1'b1;
        break;
      end
      in_valid = (i < plen) ? vpat[i] : 1'b1;
      in_data  = d0 + 32'(m_cnt);
      if (i == pulse_at) begin
        start = 1'b1; base_addr = 32'd40;
      end else begin
        start = 1'b0;
      end
      nxt();
      if (rst_after > 0 && wa_q.size() == rst_after) begin
        #1 RESET = 1'b1;
        #1;
        chk("rst_wr",       {63'd0, Wr},       64'd0);
        chk("rst_busy",     {63'd0, busy},     64'd0);
        chk("rst_wr_count", {56'd0, wr_count}, 64'd0);
        chk("rst_waddress", {32'd0, waddress}, 64'd0);
        in_valid = 1'b0; start = 1'b0;
        nxt();
        RESET = 1'b0;
        nxt(); nxt();
        chk("rst_no_done", 64'(done_n), 64'd0);
        chk("rst_idle",    {63'd0, busy}, 64'd0);
        finished = 1'b1;
        break;
      end
    end
    in_valid = 1'b0; start = 1'b0;
    chk("burst_timeout", {63'd0, finished}, 64'd1);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; base_addr = 0; word_count = 0;
    in_valid = 1'b0; in_data = 0;
    nxt(); nxt(); nxt();
    chk("reset_wr",   {63'd0, Wr},       64'd0);
    chk("reset_busy", {63'd0, busy},     64'd0);
    chk("reset_cnt",  {56'd0, wr_count}, 64'd0);
    RESET = 1'b0;
    nxt();

    // basic burst
    run_burst(32'd0, 8'd4, 32'hA0, 8'hFF, 0, -1, 0);
    chk("basic_busy_after", {63'd0, busy}, 64'd0);
    exp_a = '{32'd0, 32'd4, 32'd8, 32'd12};
    check_writes("basic", 32'hA0);
    chk("basic_done_n", 64'(done_n), 64'd1);
    chk("basic_done_with_last_wr", 64'(done_cyc), 64'(wc_q[$]));
    chk("basic_consecutive", 64'(wc_q[3] - wc_q[0]), 64'd3);
    chk("basic_wr_count", {56'd0, wr_count}, 64'd4);
    nxt();

    // wrap
    run_burst(32'd56, 8'd5, 32'h100, 8'hFF, 0, -1, 0);
    exp_a = '{32'd56, 32'd60, 32'd64, 32'd0, 32'd4};
    check_writes("wrap", 32'h100);
    chk("wrap_done_n", 64'(done_n), 64'd1);
    nxt();

    // backpressure: in_valid 1,0,0,1,0,1
    run_burst(32'd8, 8'd3, 32'h200, 8'b0010_1001, 6, -1, 0);
    exp_a = '{32'd8, 32'd12, 32'd16};
    check_writes("bp", 32'h200);
    chk("bp_gap1", 64'(wc_q[1] - wc_q[0]), 64'd3);
    chk("bp_gap2", 64'(wc_q[2] - wc_q[1]), 64'd2);
    chk("bp_wr_count", {56'd0, wr_count}, 64'd3);
    nxt();

    // zero-length burst
    run_burst(32'd24, 8'd0, 32'h300, 8'hFF, 0, -1, 0);
    chk("zero_nwrites", 64'(wa_q.size()), 64'd0);
    chk("zero_done_n", 64'(done_n), 64'd1);
    chk("zero_done_latency", 64'(done_cyc - start_cyc), 64'd1);
    chk("zero_wr_count", {56'd0, wr_count}, 64'd0);
    nxt();

    // misaligned base
    run_burst(32'h13, 8'd1, 32'h400, 8'hFF, 0, -1, 0);
    exp_a = '{32'h10};
    check_writes("misalign", 32'h400);
    nxt();

    // start pulsed mid-burst is ignored
    run_burst(32'd0, 8'd4, 32'h500, 8'hFF, 0, 1, 0);
    exp_a = '{32'd0, 32'd4, 32'd8, 32'd12};
    check_writes("ignstart", 32'h500);
    nxt(); nxt();
    chk("ignstart_idle", {63'd0, busy}, 64'd0);

    // reset after the second write of a 6-word burst
    run_burst(32'd0, 8'd6, 32'h600, 8'hFF, 0, -1, 2);
    run_burst(32'd20, 8'd2, 32'h700, 8'hFF, 0, -1, 0);
    exp_a = '{32'd20, 32'd24};
    check_writes("after_rst", 32'h700);
    chk("after_rst_done_n", 64'(done_n), 64'd1);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
